branch_target_table: RTL and testbench
======================================

Name: branch_target_table

Overview:
- Programmable successor to the fixed branch-target lookup in the fetch stage.
- Holds 2**A entries, each D bits wide, loaded at run time through a write port rather than fixed at elaboration.
- Each entry is tagged absolute or PC-relative. A relative entry is added to the current PC modulo 2**D.
- Lookup is registered with a valid/hit result. An entry-clear FSM supports flush after reset or on request.

Parameters:
- D, 10: target and PC width in bits; all target arithmetic is modulo 2**D.
- A, 4: address width; depth is 2**A entries.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  pulse: invalidate all entries (re-enter INIT)
- ready  output  1  1 = table accepts writes/lookups with real results
- wr_en  input  1  write strobe
- wr_addr  input  A  entry to write
- wr_data  input  D  absolute target or two's-complement offset
- wr_rel  input  1  1 = entry is PC-relative, 0 = absolute
- rd_req  input  1  lookup request
- rd_addr  input  A  entry to read
- pc  input  D  current PC, sampled with rd_req
- rd_valid  output  1  result valid, exactly one cycle after rd_req
- hit  output  1  entry was programmed
- target  output  D  resolved target

Behaviour:
- Storage per entry: data[D], rel bit, vld bit. Only vld needs clearing; data and rel need no reset.
- FSM states: INIT, READY.
  - rst_n low → INIT asynchronously; sweep counter = 0.
  - INIT: clears vld[counter] each cycle; counter increments. After entry 2**A−1 is cleared → READY. INIT lasts exactly 2**A cycles.
  - READY: clear=1 → INIT with counter = 0 on the next edge.
  - INIT with clear=1: counter restarts at 0.
- ready = (state == READY), registered; 0 during reset.
- Write, in READY with wr_en=1: data/rel/vld of wr_addr are updated at the edge; vld=1. Writes while ready=0 are silently dropped. A write in the same cycle clear=1 is dropped, because clear wins.
- Lookup, rd_req=1 in cycle N: rd_valid=1 in cycle N+1, for one cycle.
  - rd_req is honoured in every state. While ready=0 it behaves as a miss.
- Result rules, with entry e = rd_addr and p = pc, both sampled in cycle N:
  - ready=0 or vld[e]=0: hit=0, target = p+1 mod 2**D (fall-through).
  - vld[e]=1, rel=0: hit=1, target = data[e].
  - vld[e]=1, rel=1: hit=1, target = (p + data[e]) mod 2**D. Data is sign-agnostic: plain D-bit add, carry discarded.
- Read-during-write, same cycle and same address in READY: the lookup sees the newly written data/rel/vld (write-first bypass).
- Reset values: ready=0, rd_valid=0, hit=0, target=0.
- Outputs hold their last values when rd_valid=0; hit and target are don't-care for checking.
- Back-to-back rd_req every cycle is allowed: full throughput, one result per cycle.
- rst_n asserted mid-lookup: rd_valid drops immediately and the pending result is lost.

Decomposition:
- Shared package fetch_pkg:
  - state enum bt_state_t {BT_INIT, BT_READY}
  - localparam for the default D/A
  - function next_pc(p) = p+1 for the fall-through path
- One natural sub-module: bt_target_calc, combinational. It takes the rel flag, data, pc and vld, and produces hit and target. It is reusable by the later jump-resolve stage.
- The storage array and FSM stay in branch_target_table.

Test Plan:
- Reset, then idle: ready=0 for 16 cycles after rst_n rises, ready=1 on cycle 17; a rd_req during INIT with pc=7 → rd_valid next cycle, hit=0, target=8.
- Absolute entry: write addr 3, data 116, rel=0; lookup addr 3 with pc=50 → hit=1, target=116, one cycle later.
- Relative entry, negative offset and wrap:
  - Write addr 9, data 0x3FF, rel=1; lookup with pc=4 → target=3.
  - Write addr 9, data 20, rel=1; lookup with pc=1020 → target=16.
- Read-during-write: write addr 5, data 104, and lookup addr 5 in the same cycle → hit=1, target=104; an unwritten addr 6 → hit=0, target=pc+1.
- Clear: program addr 1 = 11, pulse clear → ready=0 for 16 cycles; lookup addr 1 afterwards → hit=0. A write issued during INIT is dropped, so its address still misses after READY.
- Async reset mid-stream: rd_req every cycle, drop rst_n between edges → rd_valid, ready, hit and target go to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and helpers used by the branch-target table and
// the later jump-resolve stage.
package fetch_pkg;

  typedef enum logic {
    BT_INIT  = 1'b0,
    BT_READY = 1'b1
  } bt_state_t;

  localparam int BT_D_DEF = 10;
  localparam int BT_A_DEF = 4;

  // Fall-through PC; callers truncate to their own PC width, so the carry
  // out of the top bit is discarded and the result wraps.
  function automatic logic [31:0] next_pc(input logic [31:0] p);
    return p + 32'd1;
  endfunction

endpackage

// File: rtl/bt_target_calc.sv
// Resolves a table entry into a hit flag and a final target: fall-through
// on a miss, stored value for absolute entries, pc + offset for relative.
module bt_target_calc
  import fetch_pkg::*;
#(
  parameter int D = BT_D_DEF
) (
  input  logic         vld,
  input  logic         rel,
  input  logic [D-1:0] data,
  input  logic [D-1:0] pc,
  output logic         hit,
  output logic [D-1:0] target
);

  // Pure combinational target selection; the offset add is a plain D-bit
  // add, so negative offsets work as two's complement and carry is dropped.
  always_comb begin
    hit    = vld;
    target = data;
    if (!vld) begin
      target = D'(next_pc(32'(pc)));
    end else if (rel) begin
      target = pc + data;
    end
  end

endmodule

// File: rtl/branch_target_table.sv
// Run-time programmable branch-target table with registered lookup, a
// write-first bypass, and a sweep FSM that invalidates every entry after
// reset or on a clear request.
module branch_target_table
  import fetch_pkg::*;
#(
  parameter int D = BT_D_DEF,
  parameter int A = BT_A_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  output logic         ready,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         wr_rel,
  input  logic         rd_req,
  input  logic [A-1:0] rd_addr,
  input  logic [D-1:0] pc,
  output logic         rd_valid,
  output logic         hit,
  output logic [D-1:0] target
);

  localparam int DEPTH = 2 ** A;
  localparam logic [A-1:0] LAST_ENTRY = {A{1'b1}};

  bt_state_t    state_q, state_d;
  logic [A-1:0] sweep_q, sweep_d;

  logic [D-1:0] data_mem [DEPTH];
  logic         rel_mem  [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic         wr_fire;
  logic         bypass;
  logic         e_vld;
  logic         e_rel;
  logic [D-1:0] e_data;
  logic         calc_hit;
  logic [D-1:0] calc_target;

  // ready comes straight from the state register, so it is glitch-free.
  assign ready = (state_q == BT_READY);

  // clear wins over a same-cycle write; writes outside READY are dropped.
  assign wr_fire = ready & wr_en & ~clear;

  // State and sweep counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BT_INIT;
      sweep_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next-state logic: sweep every entry once, restart on clear.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and a latch cannot be inferred.
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      BT_INIT: begin
        if (clear) begin
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
          if (sweep_q == LAST_ENTRY) begin
            state_d = BT_READY;
          end
        end
      end
      BT_READY: begin
        if (clear) begin
          state_d = BT_INIT;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = BT_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; an entry is only ever read
    // through its vld bit, which the INIT sweep clears.
    if (wr_fire) begin
      data_mem[wr_addr] <= wr_data;
      rel_mem[wr_addr]  <= wr_rel;
    end
  end

  // Valid bits: cleared one per cycle by the sweep, set by writes.
  always_ff @(posedge clk) begin
    if (state_q == BT_INIT) begin
      vld_q[sweep_q] <= 1'b0;
    end else if (wr_fire) begin
      vld_q[wr_addr] <= 1'b1;
    end
  end

  // Write-first bypass: a same-address write is visible to the lookup in
  // the same cycle. Anything read while not ready resolves as a miss.
  always_comb begin
    bypass = wr_fire && (wr_addr == rd_addr);
    e_vld  = ready && (bypass || vld_q[rd_addr]);
    e_rel  = bypass ? wr_rel  : rel_mem[rd_addr];
    e_data = bypass ? wr_data : data_mem[rd_addr];
  end

  bt_target_calc #(
    .D (D)
  ) u_calc (
    .vld    (e_vld),
    .rel    (e_rel),
    .data   (e_data),
    .pc     (pc),
    .hit    (calc_hit),
    .target (calc_target)
  );

  // Registered lookup result; hit/target hold when no request is made.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      hit      <= 1'b0;
      target   <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        hit    <= calc_hit;
        target <= calc_target;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table: table-driven vectors with a
// scoreboard queue, plus hand-written clear and async-reset sequences.
module tb_branch_target_table;

  localparam int D = 10;
  localparam int A = 4;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         ready;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         wr_rel;
  logic         rd_req;
  logic [A-1:0] rd_addr;
  logic [D-1:0] pc;
  logic         rd_valid;
  logic         hit;
  logic [D-1:0] target;

  branch_target_table #(.D(D), .A(A)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_rel   (wr_rel),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .pc       (pc),
    .rd_valid (rd_valid),
    .hit      (hit),
    .target   (target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic         we;
    logic [A-1:0] wa;
    logic [D-1:0] wd;
    logic         wrel;
    logic         rq;
    logic [A-1:0] ra;
    logic [D-1:0] p;
    logic         exp_hit;
    logic [D-1:0] exp_target;
  } vec_t;

  typedef struct {
    logic         exp_hit;
    logic [D-1:0] exp_target;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic mon_req;
  vec_t idle_v;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic clr_i, input logic we_i, input int wa_i, input int wd_i,
                              input logic wrel_i, input logic rq_i, input int ra_i, input int p_i,
                              input logic eh_i, input int et_i);
    vec_t v;
    v.clr = clr_i; v.we = we_i; v.wa = A'(wa_i); v.wd = D'(wd_i); v.wrel = wrel_i;
    v.rq = rq_i; v.ra = A'(ra_i); v.p = D'(p_i); v.exp_hit = eh_i; v.exp_target = D'(et_i);
    return v;
  endfunction

  // Drive one vector immediately; lookups push their expectation.
  task automatic drive(input vec_t v);
    exp_t e;
    clear   = v.clr;
    wr_en   = v.we;
    wr_addr = v.wa;
    wr_data = v.wd;
    wr_rel  = v.wrel;
    rd_req  = v.rq;
    rd_addr = v.ra;
    pc      = v.p;
    if (v.rq) begin
      e.exp_hit    = v.exp_hit;
      e.exp_target = v.exp_target;
      sb_q.push_back(e);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
  endtask

  // Monitor: one result exactly one cycle after each request.
  always begin
    @(posedge clk);
    if (mon_en) begin
      mon_req = rd_req;
      #1;
      check("rd_valid", 32'(rd_valid), 32'(mon_req));
      if (mon_req && rd_valid) begin
        if (sb_q.size() == 0) begin
          check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("hit", 32'(hit), 32'(e.exp_hit));
          check("target", 32'(target), 32'(e.exp_target));
        end
      end else if (mon_req) begin
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // clr we wa wd rel | rq ra pc | exp_hit exp_target
    tbl[0]  = mk(0, 1, 3, 116,   0, 0, 0, 0,    0, 0);
    tbl[1]  = mk(0, 0, 0, 0,     0, 1, 3, 50,   1, 116);
    tbl[2]  = mk(0, 1, 9, 10'h3FF, 1, 0, 0, 0,  0, 0);
    tbl[3]  = mk(0, 0, 0, 0,     0, 1, 9, 4,    1, 3);
    tbl[4]  = mk(0, 1, 9, 20,    1, 0, 0, 0,    0, 0);
    tbl[5]  = mk(0, 0, 0, 0,     0, 1, 9, 1020, 1, 16);
    tbl[6]  = mk(0, 1, 5, 104,   0, 1, 5, 200,  1, 104);
    tbl[7]  = mk(0, 0, 0, 0,     0, 1, 6, 300,  0, 301);
    tbl[8]  = mk(0, 0, 0, 0,     0, 1, 3, 1023, 1, 116);
    tbl[9]  = mk(0, 0, 0, 0,     0, 1, 6, 1023, 0, 0);
    tbl[10] = mk(0, 1, 7, 5,     1, 1, 7, 10,   1, 15);
    tbl[11] = mk(0, 1, 1, 11,    0, 0, 0, 0,    0, 0);
    tbl[12] = mk(0, 0, 0, 0,     0, 1, 1, 0,    1, 11);

    rst_n = 1'b0;
    drive(idle_v);
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_hit", 32'(hit), 32'd0);
    check("reset_target", 32'(target), 32'd0);

    // Release reset with a lookup during INIT: must miss with pc+1.
    mon_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 1, 0, 7, 0, 8));
    #1;
    check("init_ready_0", 32'(ready), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(idle_v);
      check($sformatf("init_ready_%0d", i), 32'(ready), 32'd0);
    end
    step(idle_v);
    check("init_ready_done", 32'(ready), 32'd1);

    // Table-driven vectors, back to back.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i]);
    end
    step(idle_v);
    step(idle_v);
    check("sb_drained_1", 32'(sb_q.size()), 32'd0);

    // Clear: entries invalidated, INIT lasts 16 cycles, INIT writes dropped.
    step(mk(1, 1, 2, 77, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      if (i == 2)      step(mk(0, 1, 12, 99, 0, 0, 0, 0, 0, 0));
      else if (i == 3) step(mk(0, 0, 0, 0, 0, 1, 1, 40, 0, 41));
      else             step(idle_v);
      check($sformatf("clear_ready_%0d", i), 32'(ready), 32'd0);
    end
    step(idle_v);
    check("clear_ready_done", 32'(ready), 32'd1);
    step(mk(0, 0, 0, 0, 0, 1, 1, 40, 0, 41));
    step(mk(0, 0, 0, 0, 0, 1, 12, 100, 0, 101));
    step(mk(0, 0, 0, 0, 0, 1, 2, 500, 0, 501));
    step(mk(0, 1, 4, 500, 0, 0, 0, 0, 0, 0));
    step(idle_v);
    step(idle_v);
    check("sb_drained_2", 32'(sb_q.size()), 32'd0);

    // Async reset mid-stream: outputs drop without a clock edge.
    @(negedge clk);
    mon_en = 1'b0;
    clear = 1'b0; wr_en = 1'b0; rd_req = 1'b1; rd_addr = 4'd4; pc = '0;
    @(posedge clk);
    #2;
    check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
    check("pre_rst_hit", 32'(hit), 32'd1);
    check("pre_rst_target", 32'(target), 32'd500);
    rst_n = 1'b0;
    #1;
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_ready", 32'(ready), 32'd0);
    check("async_hit", 32'(hit), 32'd0);
    check("async_target", 32'(target), 32'd0);
    rd_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
